// File: rtl/expand_a_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : expand_a_scheduler
// Brief   : Launches the rejection sampler K*L times (row-major) and writes
//           every returned coefficient into the matrix-A RAM.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module expand_a_scheduler #(
  parameter int K           = 6,
  parameter int L           = 5,
  parameter int ADDR_W      = 13,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [255:0]      i_rho,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rs_start,
  output logic [255:0]      o_rs_rho,
  output logic [7:0]        o_rs_row,
  output logic [7:0]        o_rs_column,
  input  logic              i_rs_coeff_valid,
  input  logic [22:0]       i_rs_coeff_data,
  input  logic              i_rs_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [22:0]       o_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_COLLECT = 3'd2,
    S_NEXT    = 3'd3,
    S_FINISH  = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [7:0]  c_LAST_ROW = 8'(K - 1);
  localparam logic [7:0]  c_LAST_COL = 8'(L - 1);
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [255:0]      r_rho;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic [8:0]        r_idx;
  logic [15:0]       r_timer;
  logic [ADDR_W-1:0] r_poly_base;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [22:0]       r_wr_data;

  logic w_start_ok;
  logic w_last_poly;
  logic w_overflow;
  logic w_complete;
  logic w_early_done;
  logic w_timeout;
  logic w_wr;

  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_FINISH) || (r_state == S_ERR));
  assign w_last_poly = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
  assign w_overflow  = i_rs_coeff_valid && r_idx[8];
  assign w_complete  = r_idx[8] && i_rs_done;
  // The first two collect cycles may still see the previous polynomial's done level.
  assign w_early_done = i_rs_done && !r_idx[8] && (r_timer >= 16'd2);
  assign w_timeout   = (r_timer == c_TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    case (r_state)
      S_IDLE, S_FINISH, S_ERR: begin
        if (i_start) begin
          w_state_nxt = S_LAUNCH;
        end else if (r_state == S_FINISH) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: w_state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (w_overflow) begin
          w_state_nxt = S_ERR;
        end else if (w_complete) begin
          w_state_nxt = S_NEXT;
        end else if (w_early_done || w_timeout) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wr = i_rs_coeff_valid;
        end
      end
      S_NEXT:  w_state_nxt = w_last_poly ? S_FINISH : S_LAUNCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rho       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_poly_base <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_poly_base + ADDR_W'(r_idx[7:0]);
        r_wr_data <= i_rs_coeff_data;
      end
      if (w_start_ok) begin
        r_rho       <= i_rho;
        r_row       <= '0;
        r_col       <= '0;
        r_poly_base <= '0;
      end
      case (r_state)
        S_LAUNCH: begin
          r_idx   <= '0;
          r_timer <= '0;
        end
        S_COLLECT: begin
          r_timer <= r_timer + 16'd1;
          if (w_wr) begin
            r_idx <= r_idx + 9'd1;
          end
        end
        S_NEXT: begin
          if (!w_last_poly) begin
            if (r_col == c_LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
            r_poly_base <= r_poly_base + ADDR_W'(256);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state == S_LAUNCH) || (r_state == S_COLLECT) || (r_state == S_NEXT);
  assign o_done      = (r_state == S_FINISH);
  assign o_err       = (r_state == S_ERR);
  assign o_rs_start  = (r_state == S_LAUNCH);
  assign o_rs_rho    = r_rho;
  assign o_rs_row    = r_row;
  assign o_rs_column = r_col;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;

endmodule
`default_nettype wire
